// File: rtl/fifo_drain_packer.sv
// ----------------------------------------------------------------------------
// fifo_drain_packer
//
// Drains words from an upstream synchronous FIFO one at a time and presents
// them downstream as fixed-length packets (PKT_LEN payload words) with
// start-of-packet / end-of-packet markers. It also keeps a running count of
// completed packets.
//
// Optional feature (macro FIFO_DRAIN_PACKER_CHECKSUM_EN):
//   When defined, every packet is followed by one extra checksum word. That
//   word is the XOR of the payload words, and pkt_eop moves onto it.
//   When undefined, pkt_eop marks payload word PKT_LEN-1 and there is no
//   checksum logic.
//
// Handshake: a packet word transfers on a rising edge where pkt_valid and
// pkt_ready are both high. pkt_data/pkt_sop/pkt_eop hold steady while
// pkt_valid is high and pkt_ready is low. pkt_ready is ignored while
// pkt_valid is low.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fifo_empty     in   upstream FIFO empty flag
//   fifo_data_out  in   upstream FIFO read data, valid one cycle after read
//   fifo_rd_en     out  upstream FIFO read strobe
//   pkt_valid      out  packet word valid
//   pkt_ready      in   downstream ready
//   pkt_data       out  packet word
//   pkt_sop        out  first word of packet
//   pkt_eop        out  last word of packet
//   pkt_count      out  completed packets (wraps at 16 bits)
//   dbg_state      out  current FSM state (FETCH=0, LOAD=1, SEND=2, TRAIL=3)
// ----------------------------------------------------------------------------
module fifo_drain_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [15:0]           pkt_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_run;
    logic [7:0]            r_word_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           r_pkt_count;
    logic                  w_last;
    logic                  w_hs;
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;
`endif

    assign w_last    = (r_word_idx == LAST_IDX);
    assign w_hs      = pkt_valid && pkt_ready;
    assign pkt_count = r_pkt_count;
    assign dbg_state = r_state;

    // Next state and outputs.
    // r_run stays low until the first edge after reset release. That keeps
    // fifo_rd_en low until then, even though the reset state is FETCH.
    always_comb begin
        w_next_state = r_state;
        fifo_rd_en   = 1'b0;
        pkt_valid    = 1'b0;
        pkt_sop      = 1'b0;
        pkt_eop      = 1'b0;
        pkt_data     = r_data;
        case (r_state)
            FETCH: begin
                fifo_rd_en = r_run && !fifo_empty;
                if (fifo_rd_en) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_next_state = SEND;
            end
            SEND: begin
                pkt_valid = 1'b1;
                pkt_sop   = (r_word_idx == 8'd0);
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
                if (pkt_ready) begin
                    w_next_state = w_last ? TRAIL : FETCH;
                end
`else
                pkt_eop = w_last;
                if (pkt_ready) begin
                    w_next_state = FETCH;
                end
`endif
            end
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
            TRAIL: begin
                pkt_valid = 1'b1;
                pkt_eop   = 1'b1;
                pkt_data  = r_checksum;
                if (pkt_ready) begin
                    w_next_state = FETCH;
                end
            end
`endif
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_run       <= 1'b0;
            r_word_idx  <= 8'd0;
            r_data      <= '0;
            r_pkt_count <= 16'd0;
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next_state;

            // FIFO read data arrives the cycle after the read strobe.
            // That cycle is LOAD.
            if (r_state == LOAD) begin
                r_data <= fifo_data_out;
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
                r_checksum <= r_checksum ^ fifo_data_out;
`endif
            end

            if (w_hs && (r_state == SEND)) begin
                if (!w_last) begin
                    r_word_idx <= r_word_idx + 8'd1;
                end
`ifndef FIFO_DRAIN_PACKER_CHECKSUM_EN
                else begin
                    r_word_idx <= 8'd0;
                end
`endif
            end

`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
            if (w_hs && (r_state == TRAIL)) begin
                r_word_idx <= 8'd0;
                r_checksum <= '0;
            end
`endif

            if (w_hs && pkt_eop) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_drain_packer
//
// Directed bench for fifo_drain_packer (DATA_WIDTH=16, PKT_LEN=4).
// The bench contains a small behavioural model of the upstream synchronous
// FIFO. Test steps load words into it. Packet words are then checked against
// hand-computed values. Expectations follow FIFO_DRAIN_PACKER_CHECKSUM_EN, so
// the bench covers whichever build variant it is compiled with.
// ----------------------------------------------------------------------------
module tb_fifo_drain_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data_out = 16'd0;
    logic        fifo_rd_en;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic [15:0] pkt_data;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [15:0] pkt_count;
    logic [1:0]  dbg_state;

    logic        push_en = 1'b0;
    logic [15:0] push_data = 16'd0;
    logic [15:0] fifo_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int rd_while_empty = 0;
    int pop_on_empty = 0;

    fifo_drain_packer #(
        .DATA_WIDTH(16),
        .PKT_LEN   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd_en   (fifo_rd_en),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_data     (pkt_data),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_count    (pkt_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- upstream sync FIFO model ----------------
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) pop_on_empty++;
            else fifo_data_out <= fifo_q.pop_front();
        end
        if (push_en) fifo_q.push_back(push_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_rd_en && fifo_empty) rd_while_empty++;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        push_en   = 1'b1;
        push_data = d;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    // Wait (bounded) for pkt_valid with pkt_ready held low, leaving the word stalled.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!pkt_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(pkt_valid), 32'd1);
    endtask

    // Accept one word, check its contents, then drop pkt_ready again.
    task automatic expect_word(input string tag, input logic [15:0] d,
                               input logic sop, input logic eop);
        int n;
        n = 0;
        pkt_ready = 1'b1;
        while (!pkt_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(pkt_valid), 32'd1);
        check({tag, "_data"}, 32'(pkt_data), 32'(d));
        check({tag, "_sop"}, 32'(pkt_sop), 32'(sop));
        check({tag, "_eop"}, 32'(pkt_eop), 32'(eop));
        @(negedge clk);
        pkt_ready = 1'b0;
    endtask

`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
    localparam logic LAST_PAYLOAD_EOP = 1'b0;
`else
    localparam logic LAST_PAYLOAD_EOP = 1'b1;
`endif

    // ---------------- directed sequence ----------------
    initial begin
        // Reset with the FIFO preloaded (fifo_empty low during reset).
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0004);
        push_word(16'h0008);
        for (int i = 0; i < 5; i++) begin
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_valid", 32'(pkt_valid), 32'd0);
            check("rst_count", 32'(pkt_count), 32'd0);
            @(negedge clk);
        end
        check("rst_data", 32'(pkt_data), 32'd0);
        check("rst_sop", 32'(pkt_sop), 32'd0);
        check("rst_eop", 32'(pkt_eop), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Release: no read before the first edge, then read/valid latency.
        rst_n = 1'b1;
        #1;
        check("rd_en_release", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        check("rd_en_first", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        check("valid_lat1", 32'(pkt_valid), 32'd0);
        @(negedge clk);
        check("valid_lat2", 32'(pkt_valid), 32'd1);

        // Packet 1: 1,2,4,8 (+0x000F checksum).
        expect_word("p1w0", 16'h0001, 1'b1, 1'b0);
        expect_word("p1w1", 16'h0002, 1'b0, 1'b0);
        expect_word("p1w2", 16'h0004, 1'b0, 1'b0);
        expect_word("p1w3", 16'h0008, 1'b0, LAST_PAYLOAD_EOP);
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
        expect_word("p1cs", 16'h000F, 1'b0, 1'b1);
`endif
        check("p1_count", 32'(pkt_count), 32'd1);
        pkt_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("p1_no_extra_valid", 32'(pkt_valid), 32'd0);
        check("p1_no_extra_rd", 32'(fifo_rd_en), 32'd0);
        pkt_ready = 1'b0;

        // Packet 2: back-pressure for 10 cycles on word 2.
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0004);
        push_word(16'h0008);
        expect_word("p2w0", 16'h0001, 1'b1, 1'b0);
        wait_valid("p2_stall");
        for (int i = 0; i < 10; i++) begin
            check("p2_stall_data", 32'(pkt_data), 32'h0002);
            check("p2_stall_valid", 32'(pkt_valid), 32'd1);
            check("p2_stall_rd", 32'(fifo_rd_en), 32'd0);
            @(negedge clk);
        end
        expect_word("p2w1", 16'h0002, 1'b0, 1'b0);
        expect_word("p2w2", 16'h0004, 1'b0, 1'b0);
        expect_word("p2w3", 16'h0008, 1'b0, LAST_PAYLOAD_EOP);
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
        expect_word("p2cs", 16'h000F, 1'b0, 1'b1);
`endif
        check("p2_count", 32'(pkt_count), 32'd2);

        // Packet 3: FIFO runs dry after 2 words and is refilled 20 cycles later.
        push_word(16'h0001);
        push_word(16'h0002);
        expect_word("p3w0", 16'h0001, 1'b1, 1'b0);
        expect_word("p3w1", 16'h0002, 1'b0, 1'b0);
        pkt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("p3_dry_valid", 32'(pkt_valid), 32'd0);
            check("p3_dry_rd", 32'(fifo_rd_en), 32'd0);
            @(negedge clk);
        end
        pkt_ready = 1'b0;
        push_word(16'h0004);
        push_word(16'h0008);
        expect_word("p3w2", 16'h0004, 1'b0, 1'b0);
        expect_word("p3w3", 16'h0008, 1'b0, LAST_PAYLOAD_EOP);
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
        expect_word("p3cs", 16'h000F, 1'b0, 1'b1);
`endif
        check("p3_count", 32'(pkt_count), 32'd3);

        // Packet 4: reset pulse while word 3 is stalled; 0x0800 stays in the FIFO.
        push_word(16'h0100);
        push_word(16'h0200);
        push_word(16'h0400);
        push_word(16'h0800);
        expect_word("p4w0", 16'h0100, 1'b1, 1'b0);
        expect_word("p4w1", 16'h0200, 1'b0, 1'b0);
        wait_valid("p4w2");
        check("p4w2_data", 32'(pkt_data), 32'h0400);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(pkt_valid), 32'd0);
        check("mid_rst_data", 32'(pkt_data), 32'd0);
        check("mid_rst_sop", 32'(pkt_sop), 32'd0);
        check("mid_rst_eop", 32'(pkt_eop), 32'd0);
        check("mid_rst_count", 32'(pkt_count), 32'd0);
        check("mid_rst_rd", 32'(fifo_rd_en), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_word(16'h1000);
        push_word(16'h2000);
        push_word(16'h4000);
        expect_word("p5w0", 16'h0800, 1'b1, 1'b0);
        expect_word("p5w1", 16'h1000, 1'b0, 1'b0);
        expect_word("p5w2", 16'h2000, 1'b0, 1'b0);
        expect_word("p5w3", 16'h4000, 1'b0, LAST_PAYLOAD_EOP);
`ifdef FIFO_DRAIN_PACKER_CHECKSUM_EN
        expect_word("p5cs", 16'h7800, 1'b0, 1'b1);
`endif
        check("p5_count", 32'(pkt_count), 32'd1);

        check("rd_while_empty", 32'(rd_while_empty), 32'd0);
        check("pop_on_empty", 32'(pop_on_empty), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
